// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity-type codes
// common to the transmit and receive halves.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int MIN_PRESCALE   = 4;
   localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the transmitter; presents the
// bit that will be on the line after the current edge.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  shift_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ser_data_o,
   output logic                  ser_done_o
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

   assign ser_done_o = (bit_cnt_q == CW'(DATA_WIDTH - 1));
   // Look-ahead so the registered line output lines up with the shift.
   assign ser_data_o = shift_d[0];

   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      if (load_i) begin
         shift_d   = data_i;
         bit_cnt_d = '0;
      end else if (shift_i) begin
         shift_d   = shift_q >> 1;
         bit_cnt_d = ser_done_o ? '0 : bit_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop
// bit, with bit timing from a runtime clock-per-bit prescaler.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   tx_state_e state_q, state_d;

   logic [PRESCALE_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;

   logic accept;
   logic bound;
   logic ser_shift;
   logic ser_data;
   logic ser_done;

   assign accept    = (state_q == IDLE) && Data_Valid;
   assign bound     = (state_q != IDLE) &&
                      (clk_cnt_q == presc_q - PRESCALE_W'(1));
   assign ser_shift = (state_q == DATA) && bound;

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept),
      .shift_i    (ser_shift),
      .data_i     (P_DATA),
      .ser_data_o (ser_data),
      .ser_done_o (ser_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (accept) state_d = START;
         START:  if (bound)  state_d = DATA;
         DATA:   if (bound && ser_done)
                    state_d = par_en_q ? PARITY : STOP;
         PARITY: if (bound)  state_d = STOP;
         STOP:   if (bound)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the next state so the line flop changes with the state.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      unique case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = ser_data;
         PARITY:  tx_d = par_bit_q;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      presc_d   = presc_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      clk_cnt_d = (state_q == IDLE || bound) ? '0
                                             : clk_cnt_q + PRESCALE_W'(1);
      if (accept) begin
         presc_d   = (Prescale < PRESCALE_W'(MIN_PRESCALE))
                     ? PRESCALE_W'(MIN_PRESCALE) : Prescale;
         par_en_d  = PAR_EN;
         par_bit_d = (^P_DATA) ^ (PAR_TYP != PAR_EVEN);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_cnt_q <= '0;
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle expected line/busy values
// queued from a frame model and compared on the falling edge.
module tb_uart_tx;
   import uart_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       busy;

   uart_tx #(
      .DATA_WIDTH (8),
      .PRESCALE_W (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic [5:0] presc;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   typedef struct {
      logic tx;
      logic busy;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;

   task automatic push_bit(input logic b, input int n);
      exp_t e;
      e.tx   = b;
      e.busy = 1'b1;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e.tx   = 1'b1;
      e.busy = 1'b0;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] d, input logic pe,
                             input logic par, input int n);
      push_bit(1'b0, n);
      for (int i = 0; i < 8; i++) push_bit(d[i], n);
      if (pe) push_bit(par, n);
      push_bit(1'b1, n);
      push_idle(1);
   endtask

   task automatic check(input string tag);
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sb.size() == 0) begin
         e.tx   = 1'b1;
         e.busy = 1'b0;
      end else begin
         e = sb.pop_front();
      end
      checks++;
      if (TX_OUT !== e.tx || busy !== e.busy) begin
         fails++;
         $display("FAIL %s: cycle %0d TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
                  tag, cyc, TX_OUT, busy, e.tx, e.busy);
      end
   endtask

   task automatic check_n(input string tag, input int n);
      for (int i = 0; i < n; i++) check(tag);
   endtask

   task automatic drain(input string tag);
      int n;
      n = sb.size();
      check_n(tag, n);
   endtask

   task automatic send(input vec_t v, input string tag);
      P_DATA     = v.data;
      PAR_EN     = v.pe;
      PAR_TYP    = v.pt;
      Prescale   = v.presc;
      Data_Valid = 1'b1;
      push_frame(v.data, v.pe, v.exp_par, v.exp_len);
      check(tag);
      Data_Valid = 1'b0;
      drain(tag);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, PAR_EVEN, 6'd8,  1'b0, 8};
      vecs[1] = '{8'h01, 1'b1, PAR_ODD,  6'd16, 1'b0, 16};
      vecs[2] = '{8'h01, 1'b0, PAR_ODD,  6'd16, 1'b0, 16};
      vecs[3] = '{8'hC3, 1'b1, PAR_ODD,  6'd5,  1'b1, 5};
      vecs[4] = '{8'h00, 1'b1, PAR_ODD,  6'd1,  1'b1, 4};
      vecs[5] = '{8'hFF, 1'b0, PAR_EVEN, 6'd0,  1'b0, 4};
      vecs[6] = '{8'h96, 1'b1, PAR_EVEN, 6'd2,  1'b0, 4};

      rst        = 1'b0;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd8;

      push_idle(3);
      check_n("reset", 3);
      rst = 1'b1;
      push_idle(20);
      drain("idle");

      for (int i = 0; i < 7; i++) begin
         send(vecs[i], $sformatf("vec%0d", i));
         push_idle(2);
         drain($sformatf("vec%0d_gap", i));
      end

      // Requests and input changes during a frame must be ignored.
      P_DATA     = 8'h3C;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd8;
      Data_Valid = 1'b1;
      push_frame(8'h3C, 1'b0, 1'b0, 8);
      check("ignore");
      Data_Valid = 1'b0;
      check_n("ignore", 19);
      Data_Valid = 1'b1;
      P_DATA     = 8'hFF;
      Prescale   = 6'd4;
      check_n("ignore", 40);
      Data_Valid = 1'b0;
      drain("ignore");
      push_idle(5);
      drain("ignore_idle");

      // Held request gives two frames with a single idle cycle between.
      P_DATA     = 8'h55;
      Prescale   = 6'd4;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      push_frame(8'h55, 1'b0, 1'b0, 4);
      push_frame(8'hAA, 1'b0, 1'b0, 4);
      check("b2b");
      P_DATA = 8'hAA;
      check_n("b2b", 40);
      check("b2b");
      Data_Valid = 1'b0;
      drain("b2b");
      push_idle(3);
      drain("b2b_idle");

      // Asynchronous reset in the third data bit (a 0 bit of 0x3B).
      P_DATA     = 8'h3B;
      PAR_EN     = 1'b1;
      PAR_TYP    = PAR_EVEN;
      Prescale   = 6'd8;
      Data_Valid = 1'b1;
      push_frame(8'h3B, 1'b1, 1'b1, 8);
      check("midrst");
      Data_Valid = 1'b0;
      check_n("midrst", 25);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midrst_async: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  TX_OUT, busy);
      end
      sb.delete();
      push_idle(2);
      check_n("midrst_hold", 2);
      rst = 1'b1;
      push_idle(12);
      drain("midrst_after");

      send('{8'h96, 1'b1, PAR_EVEN, 6'd2, 1'b0, 4}, "clamp");
      push_idle(3);
      drain("clamp_idle");

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: serializes a parallel byte into an idle-high asynchronous frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Bit timing comes from an internal clock-per-bit counter driven by a runtime Prescale value, so TX and RX share one system clock.
- Sits between the host/register interface and the serial pin, as the transmit half of the UART beside the receiver.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the Prescale port and of the internal clock-per-bit counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  byte to transmit; captured on acceptance
Data_Valid  input  1  request to send P_DATA; accepted only when busy=0
PAR_EN  input  1  1 = append parity bit; captured on acceptance
PAR_TYP  input  1  0 = even parity, 1 = odd; captured on acceptance
Prescale  input  PRESCALE_W  clocks per serial bit; captured on acceptance; values <4 are treated as 4
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  registered; high from first start-bit cycle through last stop-bit cycle

Behaviour:
- Reset (asynchronous, rst=0): state=IDLE, TX_OUT=1, busy=0, all counters=0, shift register=0. Takes effect immediately, including mid-frame. No partial frame resumes after reset release.
- Acceptance: rising edge where state=IDLE and Data_Valid=1.
  - Latches P_DATA, PAR_EN, PAR_TYP and the clamped Prescale.
  - Computes parity from the latched data: even = XOR of data bits; odd = inverted XOR.
- Latency: acceptance at edge N. TX_OUT=0 and busy=1 are visible after edge N, i.e. one cycle latency, no combinational path from inputs to outputs.
- Data_Valid while busy=1 is ignored, not queued. Changes to P_DATA, PAR_EN, PAR_TYP or Prescale during a frame have no effect.
- State machine, one-hot encoding or enum, next-state combinational, state register on clk/rst:
  - IDLE: TX_OUT=1, busy=0. Goes to START on acceptance.
  - START: TX_OUT=0 for Prescale clocks, then DATA.
  - DATA: TX_OUT=shift[0], shifts right at each bit boundary. Each bit is held Prescale clocks. After DATA_WIDTH bits, goes to PARITY if latched PAR_EN=1, otherwise STOP.
  - PARITY: TX_OUT=parity bit for Prescale clocks, then STOP.
  - STOP: TX_OUT=1 for Prescale clocks, then IDLE.
- Counters:
  - clk_cnt counts 0..Prescale-1 and wraps to 0 at each bit boundary. The boundary is the cycle where clk_cnt==Prescale-1.
  - bit_cnt counts data bits 0..DATA_WIDTH-1 and clears on leaving DATA.
  - All arithmetic is unsigned at PRESCALE_W bits. No overflow is possible because Prescale-1 fits the width.
- Frame duration with busy=1: (2 + DATA_WIDTH + PAR_EN) * Prescale clocks exactly.
- Back-to-back frames: busy drops for at least one IDLE cycle between frames. A Data_Valid held high is accepted on that IDLE cycle. The minimum frame-to-frame period is the frame duration + 1 clock.
- TX_OUT is always driven from a flop and never glitches. There are no X values on outputs after reset.

Decomposition:
- Shared package uart_pkg:
  - tx_state_e enum {IDLE, START, DATA, PARITY, STOP}
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1, MIN_PRESCALE=4, default DATA_WIDTH=8
  - The package is shared with the receiver for parity-type encoding.
- One natural sub-module: uart_tx_serializer (shift register + bit counter, load/shift controls from the FSM, outputs ser_data and ser_done).
- Parity calculation and the clock-per-bit counter stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release, Data_Valid=0 for 20 cycles -> TX_OUT=1 and busy=0 throughout.
- Even parity, Prescale=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> one cycle later TX_OUT sequence per 8-clock bit is 0,1,0,1,0,0,1,0,1,0(parity),1(stop). busy high exactly 88 cycles.
- Odd parity vs none: P_DATA=0x01, Prescale=16:
  - PAR_TYP=1 -> parity bit 0, busy 176 cycles
  - PAR_EN=0 -> no parity bit, busy 160 cycles, stop bit follows the 8th data bit directly
- Ignore while busy: during a frame of 0x3C, assert Data_Valid with P_DATA=0xFF and change Prescale to 4 -> frame is still 0x3C at the original rate. The 0xFF request is not sent unless still asserted in IDLE.
- Back-to-back: Data_Valid held high with P_DATA=0x55 then 0xAA, Prescale=4, PAR_EN=0 -> two 40-cycle frames separated by exactly one IDLE cycle with TX_OUT=1 and busy=0.
- Mid-frame reset and clamp:
  - rst pulsed low in the 3rd data bit -> TX_OUT=1 and busy=0 immediately (asynchronous), no continuation after release.
  - Then Prescale=2 -> each bit lasts 4 clocks.
